// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_arbiter
// Description : Shares a single-port, word-addressable data RAM between two
//               requesters (A: core load/store unit, B: debug/DMA loader).
//               Level-held requests are granted one at a time, round-robin on
//               contention. Each grant runs IDLE -> ACCESS -> RESP: the
//               winning transaction is latched at the grant edge, drives the
//               RAM for exactly one cycle, then returns registered read data
//               with a one-cycle ack pulse.
//
// Configuration macro:
//   DATA_RAM_ARB_FIXED_PRIO_EN  defined   : port A always wins contention
//                               undefined : round-robin (default)
//
// Parameters:
//   N  byte address width (RAM is indexed by addr[N-1:2])
//   M  data width
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/b_req                request, held high until matching ack
//   a_we/b_we                  1 = write, 0 = read
//   a_addr/b_addr   [N-1:0]    byte address
//   a_wdata/b_wdata [M-1:0]    write data
//   a_ack/b_ack                one-cycle completion pulse (registered)
//   a_rdata/b_rdata [M-1:0]    registered read data, held until next read
//   ram_we/ram_addr/ram_wdata  RAM control, address and write data
//   ram_rdata       [M-1:0]    combinational RAM read data
//
// Revision    : 1.0  initial release
// ============================================================================
module data_ram_arbiter #(
  parameter int N = 10,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req,
  input  logic         a_we,
  input  logic [N-1:0] a_addr,
  input  logic [M-1:0] a_wdata,
  output logic         a_ack,
  output logic [M-1:0] a_rdata,
  input  logic         b_req,
  input  logic         b_we,
  input  logic [N-1:0] b_addr,
  input  logic [M-1:0] b_wdata,
  output logic         b_ack,
  output logic [M-1:0] b_rdata,
  output logic         ram_we,
  output logic [N-1:0] ram_addr,
  output logic [M-1:0] ram_wdata,
  input  logic [M-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_cur_we;
  logic [N-1:0]   r_cur_addr;
  logic [M-1:0]   r_cur_wdata;
  logic           r_owner;      // 0 = port A, 1 = port B
  logic           w_grant_b;    // B wins the current IDLE slot

`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
  // A always wins; B only when it is the sole requester.
  assign w_grant_b = b_req & ~a_req;
`else
  logic           r_last_owner; // owner of the most recent completed access

  // B wins when alone, or on contention when A was served last.
  assign w_grant_b = b_req & (~a_req | ~r_last_owner);
`endif

  // RAM is only written during the single ACCESS cycle.
  assign ram_we    = (r_state == S_ACCESS) & r_cur_we;
  assign ram_addr  = r_cur_addr;
  assign ram_wdata = r_cur_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_we     <= 1'b0;
      r_cur_addr   <= '0;
      r_cur_wdata  <= '0;
      r_owner      <= 1'b0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
`ifndef DATA_RAM_ARB_FIXED_PRIO_EN
      r_last_owner <= 1'b1;       // start as if B was last so A wins first
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (a_req || b_req) begin
            // Requester inputs are sampled only here.
            r_owner     <= w_grant_b;
            r_cur_we    <= w_grant_b ? b_we    : a_we;
            r_cur_addr  <= w_grant_b ? b_addr  : a_addr;
            r_cur_wdata <= w_grant_b ? b_wdata : a_wdata;
            r_state     <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (r_owner) begin
            b_ack <= 1'b1;
            if (!r_cur_we) b_rdata <= ram_rdata;
          end else begin
            a_ack <= 1'b1;
            if (!r_cur_we) a_rdata <= ram_rdata;
          end
`ifndef DATA_RAM_ARB_FIXED_PRIO_EN
          r_last_owner <= r_owner;
`endif
          r_state <= S_RESP;
        end

        S_RESP: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_arbiter
// Description : Directed self-checking bench for data_ram_arbiter. Includes a
//               word-addressable RAM model (reset contents 0, synchronous
//               write, combinational read).
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_ram_arbiter;

  localparam int N = 10;
  localparam int M = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_req, a_we, b_req, b_we;
  logic [N-1:0] a_addr, b_addr;
  logic [M-1:0] a_wdata, b_wdata;
  logic         a_ack, b_ack;
  logic [M-1:0] a_rdata, b_rdata;
  logic         ram_we;
  logic [N-1:0] ram_addr;
  logic [M-1:0] ram_wdata;
  logic [M-1:0] ram_rdata;

  int tests = 0;
  int fails = 0;

  logic [M-1:0] mem [256] = '{default: '0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[N-1:2]] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr[N-1:2]];

  data_ram_arbiter #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_set(input bit port, input bit we, input logic [N-1:0] addr,
                         input logic [M-1:0] wd);
    if (port) begin
      b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    end
  endtask

  // Waits (bounded) for the given port's ack; cyc = edges elapsed.
  task automatic wait_ack(input bit port, input string tag, output int cyc);
    cyc = 0;
    while (cyc < 10) begin
      step();
      cyc++;
      if (port ? b_ack : a_ack) break;
    end
    check({tag, " ack"}, {31'd0, (port ? b_ack : a_ack)}, 32'd1);
  endtask

  // Single transaction: request, wait ack, check latency, drop, return to IDLE.
  task automatic txn(input bit port, input bit we, input logic [N-1:0] addr,
                     input logic [M-1:0] wd, input string tag);
    int cyc;
    req_set(port, we, addr, wd);
    wait_ack(port, tag, cyc);
    check({tag, " latency"}, cyc, 32'd2);
    if (port) b_req = 1'b0; else a_req = 1'b0;
    step();
  endtask

  initial begin
    int cyc;
    logic exp_a, exp_b;

    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    // ---- Reset with both requests driven --------------------------------
    req_set(1'b0, 1'b1, 10'h010, 32'hFFFF_FFFF);
    req_set(1'b1, 1'b1, 10'h014, 32'hFFFF_FFFF);
    repeat (3) step();
    check("rst a_ack",   {31'd0, a_ack},  32'd0);
    check("rst b_ack",   {31'd0, b_ack},  32'd0);
    check("rst a_rdata", a_rdata,         32'd0);
    check("rst b_rdata", b_rdata,         32'd0);
    check("rst ram_we",  {31'd0, ram_we}, 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;
    step();

    // ---- A write 0xDEADBEEF to 0x010, first grant after release ---------
    req_set(1'b0, 1'b1, 10'h010, 32'hDEAD_BEEF);
    step();
    check("wr ram_we",    {31'd0, ram_we},   32'd1);
    check("wr ram_addr",  {22'd0, ram_addr}, 32'h010);
    check("wr ram_wdata", ram_wdata,         32'hDEAD_BEEF);
    step();
    check("wr a_ack",     {31'd0, a_ack},    32'd1);
    check("wr ram_we off",{31'd0, ram_we},   32'd0);
    check("wr a_rdata",   a_rdata,           32'd0);
    a_req = 1'b0;
    step();
    check("wr ack pulse", {31'd0, a_ack},    32'd0);
    check("wr mem",       mem[4],            32'hDEAD_BEEF);

    // ---- A read 0x010 ----------------------------------------------------
    txn(1'b0, 1'b0, 10'h010, 32'd0, "rdA");
    check("rdA a_rdata", a_rdata, 32'hDEAD_BEEF);
    check("rdA b_rdata", b_rdata, 32'd0);

    // ---- Preset 0x000 = 0x11 (A), 0x004 = 0x22 (B) ----------------------
    txn(1'b0, 1'b1, 10'h000, 32'h11, "pre0");
    txn(1'b1, 1'b1, 10'h004, 32'h22, "pre4");
    check("pre a_rdata kept", a_rdata, 32'hDEAD_BEEF);

    // ---- Contention: both read continuously -----------------------------
    req_set(1'b0, 1'b0, 10'h000, 32'd0);
    req_set(1'b1, 1'b0, 10'h004, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      step();
`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
      exp_a = (c % 3 == 2);
      exp_b = 1'b0;
`else
      exp_a = (c == 2) || (c == 8);
      exp_b = (c == 5) || (c == 11);
`endif
      check($sformatf("cont a_ack c%0d", c), {31'd0, a_ack}, {31'd0, exp_a});
      check($sformatf("cont b_ack c%0d", c), {31'd0, b_ack}, {31'd0, exp_b});
    end
    a_req = 1'b0; b_req = 1'b0;
    step();
    check("cont a_rdata", a_rdata, 32'h11);
`ifdef DATA_RAM_ARB_FIXED_PRIO_EN
    check("cont b_rdata", b_rdata, 32'd0);
`else
    check("cont b_rdata", b_rdata, 32'h22);
`endif

    // ---- Address change during ACCESS does not affect write --------------
    req_set(1'b0, 1'b1, 10'h020, 32'hCAFE_F00D);
    step();
    a_addr = 10'h030; a_wdata = 32'h1234_5678;
    #1;
    check("chg ram_addr",  {22'd0, ram_addr}, 32'h020);
    check("chg ram_wdata", ram_wdata,         32'hCAFE_F00D);
    step();
    check("chg a_ack", {31'd0, a_ack}, 32'd1);
    a_req = 1'b0;
    step();
    check("chg mem 0x020", mem[8],  32'hCAFE_F00D);
    check("chg mem 0x030", mem[12], 32'd0);

    // ---- Reset in the middle of a B write --------------------------------
    req_set(1'b1, 1'b1, 10'h040, 32'h55);
    step();
    check("abort ram_we before", {31'd0, ram_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort ram_we",   {31'd0, ram_we},   32'd0);
    check("abort ram_addr", {22'd0, ram_addr}, 32'd0);
    check("abort b_ack",    {31'd0, b_ack},    32'd0);
    check("abort b_rdata",  b_rdata,           32'd0);
    b_req = 1'b0;
    step();
    check("abort b_ack edge", {31'd0, b_ack}, 32'd0);
    check("abort mem",        mem[16],        32'd0);
    rst_n = 1'b1;
    step();
    txn(1'b1, 1'b0, 10'h040, 32'd0, "abort rd");
    check("abort rd b_rdata", b_rdata, 32'd0);
    check("abort a_rdata", a_rdata, 32'd0);

    // ---- B burst of writes with b_req held -------------------------------
    req_set(1'b1, 1'b1, 10'h0FC, 32'h1);
    wait_ack(1'b1, "burst1", cyc);
    check("burst1 latency", cyc, 32'd2);
    b_wdata = 32'h2;
    wait_ack(1'b1, "burst2", cyc);
    check("burst2 spacing", cyc, 32'd3);
    b_wdata = 32'h3;
    wait_ack(1'b1, "burst3", cyc);
    check("burst3 spacing", cyc, 32'd3);
    b_req = 1'b0;
    step();
    check("burst b_rdata kept", b_rdata, 32'd0);
    txn(1'b1, 1'b0, 10'h0FC, 32'd0, "burst rd");
    check("burst rd b_rdata", b_rdata, 32'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
